// File: rtl/state_dump_pkg.sv
// Shared types and constants for the state_dump block.
// Optional checksum beat is controlled by the DUMP_CHECKSUM_EN macro.
package state_dump_pkg;

  localparam int REG_COUNT = 32;

  localparam logic [1:0] TAG_REG  = 2'd0;
  localparam logic [1:0] TAG_MEM  = 2'd1;
  localparam logic [1:0] TAG_CSUM = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REG_RD = 3'd1,
    MEM_RD = 3'd2,
    EMIT   = 3'd3,
`ifdef DUMP_CHECKSUM_EN
    CSUM   = 3'd4,
`endif
    FIN    = 3'd5
  } state_t;

  // Byte address of lane `lane` within 32-bit memory word `word`.
  function automatic logic [31:0] mem_byte_addr(input logic [7:0] word, input logic [1:0] lane);
    return {22'd0, word, lane};
  endfunction

endpackage

// File: rtl/state_dump_if.sv
// Output beat channel of the state dumper.
interface state_dump_if;
  import state_dump_pkg::*;

  // A beat transfers on a rising clk edge where out_valid and out_ready are both 1.
  // While out_valid is 1 and out_ready is 0 the source holds out_data/out_tag/out_index stable.
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic [7:0]  out_index;

  modport master (output out_valid, out_data, out_tag, out_index, input out_ready);
  modport slave  (input out_valid, out_data, out_tag, out_index, output out_ready);

endinterface

// File: rtl/dump_word_gather.sv
// Assembles four successive little-endian memory bytes into one 32-bit word.
module dump_word_gather (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_idx,
  output logic        word_ready,
  output logic [31:0] word
);

  // Earlier bytes shift down so byte 0 ends up in the lowest lane.
  logic [23:0] lanes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= 2'd0;
      lanes    <= 24'd0;
    end else if (en) begin
      byte_idx <= byte_idx + 2'd1;
      lanes    <= {byte_in, lanes[23:8]};
    end
  end

  assign word_ready = en && (byte_idx == 2'd3);
  assign word       = {byte_in, lanes};

endmodule

// File: rtl/state_dump.sv
// Dumps the 32 registers then DM_WORDS memory words as tagged beats.
// Define DUMP_CHECKSUM_EN to append an XOR checksum beat (tag 2).
module state_dump
  import state_dump_pkg::*;
#(
  parameter int DM_WORDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [4:0]   rf_raddr,
  input  logic [31:0]  rf_rdata,
  output logic [31:0]  dm_raddr,
  input  logic [7:0]   dm_rdata,
  state_dump_if.master beat,
  output state_t       dbg_state
);

  localparam logic [7:0] LAST_REG  = 8'(REG_COUNT - 1);
  localparam logic [7:0] LAST_WORD = 8'(DM_WORDS - 1);

  state_t      state, state_n;
  logic [7:0]  index, index_n;
  logic        hs;
  logic [1:0]  byte_idx;
  logic        word_ready;
  logic [31:0] word;

  dump_word_gather u_gather (
    .clk        (clk),
    .rst        (rst),
    .en         (state == MEM_RD),
    .byte_in    (dm_rdata),
    .byte_idx   (byte_idx),
    .word_ready (word_ready),
    .word       (word)
  );

`ifdef DUMP_CHECKSUM_EN
  logic [31:0] csum_acc;
  assign beat.out_valid = (state == EMIT) || (state == CSUM);
`else
  assign beat.out_valid = (state == EMIT);
`endif

  assign hs        = beat.out_valid && beat.out_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign rf_raddr  = (state == REG_RD) ? index[4:0] : 5'd0;
  assign dm_raddr  = (state == MEM_RD) ? mem_byte_addr(index, byte_idx) : 32'd0;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    index_n = index;
    case (state)
      IDLE: if (start) begin
        state_n = REG_RD;
        index_n = 8'd0;
      end
      REG_RD: state_n = EMIT;
      MEM_RD: if (word_ready) state_n = EMIT;
      EMIT: if (hs) begin
        if (beat.out_tag == TAG_REG) begin
          state_n = (index == LAST_REG) ? MEM_RD : REG_RD;
          index_n = (index == LAST_REG) ? 8'd0 : index + 8'd1;
        end else if (index == LAST_WORD) begin
`ifdef DUMP_CHECKSUM_EN
          state_n = CSUM;
`else
          state_n = FIN;
`endif
          index_n = 8'd0;
        end else begin
          state_n = MEM_RD;
          index_n = index + 8'd1;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CSUM: if (hs) state_n = FIN;
`endif
      FIN: begin
        state_n = IDLE;
        index_n = 8'd0;
      end
      default: begin
        state_n = IDLE;
        index_n = 8'd0;
      end
    endcase
  end

  // Beat registers load on entry to EMIT/CSUM and are otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index          <= 8'd0;
      beat.out_data  <= 32'd0;
      beat.out_tag   <= 2'd0;
      beat.out_index <= 8'd0;
    end else begin
      index <= index_n;
      case (state)
        REG_RD: begin
          beat.out_data  <= rf_rdata;
          beat.out_tag   <= TAG_REG;
          beat.out_index <= index;
        end
        MEM_RD: if (word_ready) begin
          beat.out_data  <= word;
          beat.out_tag   <= TAG_MEM;
          beat.out_index <= index;
        end
`ifdef DUMP_CHECKSUM_EN
        EMIT: if (state_n == CSUM) begin
          // Fold in the final memory beat, which handshakes on this same edge.
          beat.out_data  <= csum_acc ^ beat.out_data;
          beat.out_tag   <= TAG_CSUM;
          beat.out_index <= 8'd0;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        csum_acc <= 32'd0;
    else if (state == IDLE)         csum_acc <= 32'd0;
    else if ((state == EMIT) && hs) csum_acc <= csum_acc ^ beat.out_data;
  end
`else
`endif

endmodule

// File: tb/tb_state_dump.sv
// Randomized self-checking bench for state_dump against a beat-list reference model.
module tb_state_dump;
  import state_dump_pkg::*;

  localparam int DMW = 4;
`ifdef DUMP_CHECKSUM_EN
  localparam int CSUM_BEATS = 1;
`else
  localparam int CSUM_BEATS = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] dm_raddr;
  logic [7:0]  dm_rdata;
  state_t      dbg_state;

  logic [31:0] rf_mem [32];
  logic [7:0]  dm_mem [DMW*4];

  state_dump_if bus ();

  state_dump #(.DM_WORDS(DMW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .dm_raddr  (dm_raddr),
    .dm_rdata  (dm_rdata),
    .beat      (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rdata = rf_mem[rf_raddr];
  assign dm_rdata = (dm_raddr < 32'(DMW*4)) ? dm_mem[dm_raddr[3:0]] : 8'h00;

  // ---------------- scoreboard ----------------
  int tests  = 0;
  int errors = 0;
  int beats  = 0;
  int n_exp  = 0;
  int done_cnt = 0;
  logic [41:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the dump is simply every register, then every memory word, then the XOR.
  task automatic build_expected();
    logic [31:0] csum;
    logic [31:0] w;
    exp_q.delete();
    csum = 32'd0;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back({TAG_REG, 8'(i), rf_mem[i]});
      csum ^= rf_mem[i];
    end
    for (int m = 0; m < DMW; m++) begin
      w = 32'(dm_mem[4*m]) | (32'(dm_mem[4*m+1]) << 8) |
          (32'(dm_mem[4*m+2]) << 16) | (32'(dm_mem[4*m+3]) << 24);
      exp_q.push_back({TAG_MEM, 8'(m), w});
      csum ^= w;
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back({TAG_CSUM, 8'd0, csum});
`endif
    n_exp = exp_q.size();
    beats = 0;
  endtask

  always @(negedge clk) begin
    logic [41:0] got;
    logic [41:0] e;
    if (!rst) begin
      if (done) done_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        beats++;
        got = {bus.out_tag, bus.out_index, bus.out_data};
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat", 64'(got), 64'(e));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic fill_identity();
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i);
    for (int i = 0; i < DMW*4; i++) dm_mem[i] = 8'h00;
    dm_mem[0] = 8'h78;
    dm_mem[1] = 8'h56;
    dm_mem[2] = 8'h34;
    dm_mem[3] = 8'h12;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    for (int i = 0; i < DMW*4; i++) dm_mem[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic run_dump(input bit rand_ready, input int stall_idx, input bit mid_start);
    int busy_cycles = 0;
    int lat = 0;
    int stalled = 0;
    int dc0;
    bit lat_seen = 0, stall_on = 0, stall_seen = 0, req = 0, pulsed = 0, fin = 0;
    build_expected();
    dc0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready_drive(rand_ready, 1'b0);
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(posedge clk); #1;
      start = req;
      req = 1'b0;
      out_ready_drive(rand_ready, stall_on);
      @(negedge clk);
      if (busy) busy_cycles++;
      if (!lat_seen && bus.out_valid) begin
        lat = cyc;
        lat_seen = 1'b1;
      end
      if (stall_on && (bus.out_valid || stall_seen)) begin
        stall_seen = 1'b1;
        check("stall_valid", 64'(bus.out_valid), 64'(1));
        check("stall_data", 64'(bus.out_data), 64'(rf_mem[stall_idx]));
        check("stall_rf_raddr", 64'(rf_raddr), 64'(0));
        stalled++;
        if (stalled == 10) stall_on = 1'b0;
      end
      if (stall_idx > 0 && stalled == 0 && !stall_on && bus.out_valid && bus.out_ready &&
          bus.out_tag == TAG_REG && bus.out_index == 8'(stall_idx - 1))
        stall_on = 1'b1;
      if (mid_start && !pulsed && bus.out_valid && bus.out_tag == TAG_MEM) begin
        req = 1'b1;
        pulsed = 1'b1;
      end
      if (done) begin
        fin = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(fin), 64'(1));
    check("first_valid_latency", 64'(lat), 64'(2));
    if (!rand_ready && stall_idx < 0)
      check("dump_cycles", 64'(busy_cycles), 64'(64 + 5*DMW + 1 + CSUM_BEATS));
    if (stall_idx > 0) check("stall_cycles", 64'(stalled), 64'(10));
    if (mid_start) check("mid_start_pulsed", 64'(pulsed), 64'(1));
    start = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after", 64'(busy), 64'(0));
    check("done_pulses", 64'(done_cnt - dc0), 64'(1));
    check("beat_count", 64'(beats), 64'(n_exp));
    check("exp_left", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic out_ready_drive(input bit rand_ready, input bit hold_low);
    if (hold_low)        bus.out_ready = 1'b0;
    else if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    else                 bus.out_ready = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_data"}, 64'(bus.out_data), 64'(0));
    check({tag, "_tag"}, 64'(bus.out_tag), 64'(0));
    check({tag, "_index"}, 64'(bus.out_index), 64'(0));
    check({tag, "_rf_raddr"}, 64'(rf_raddr), 64'(0));
    check({tag, "_dm_raddr"}, 64'(dm_raddr), 64'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit hit;
    rst = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b1;
    fill_identity();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;

    // identity registers, word 0 = 0x12345678, ready always high
    fill_identity();
    run_dump(1'b0, -1, 1'b0);

    // random contents with random back-pressure
    for (int r = 0; r < 2; r++) begin
      fill_random();
      run_dump(1'b1, -1, 1'b0);
    end

    // hold off register 5 for ten cycles
    fill_identity();
    run_dump(1'b0, 5, 1'b0);

    // start pulse during the memory phase must be ignored
    fill_random();
    run_dump(1'b0, -1, 1'b1);

    // reset in the middle of reading memory word 2
    fill_random();
    build_expected();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (dm_raddr == 32'd9) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort_reached", 64'(hit), 64'(1));
    #1 rst = 1'b1;
    #1;
    check_all_zero("abort");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    fill_identity();
    run_dump(1'b0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
